update_sched: RTL and testbench
===============================

UPDATE_SCHED -- requirements
Module: update_sched

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, meaning the number of requesters sharing the update port.
REQ-002 The block SHALL have parameter W, default 10, meaning the width of the shared vector.
REQ-003 The block SHALL have parameter SETTLE, default 3, meaning the number of write-free cycles before stable asserts.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: the reset, synchronous and active-high.
REQ-006 The block SHALL have port req, input, NREQ bits: per-requester update request.
REQ-007 The block SHALL have port idx, input, NREQ x IDXW bits: per-requester target bit index, with IDXW = clog2(W).
REQ-008 The block SHALL have port val, input, NREQ bits: per-requester value to write.
REQ-009 The block SHALL have port gnt, output, NREQ bits: one-hot grant pulse, registered.
REQ-010 The block SHALL have port vec, output, W bits: the shared vector, registered.
REQ-011 The block SHALL have port chg, output, 1 bit: a one-cycle pulse when vec changed value this cycle.
REQ-012 The block SHALL have port stable, output, 1 bit: no write for at least SETTLE cycles.
REQ-013 The block SHALL have port err, output, 1 bit: sticky flag for an out-of-range index.

Function
REQ-014 Each cycle, the arbiter SHALL pick at most one winner among eligible req bits, round-robin, starting from pointer ptr.
REQ-015 After a grant to requester w, ptr SHALL become (w+1) mod NREQ; with no grant, ptr SHALL hold.
REQ-016 The winner of cycle t SHALL see gnt[w]=1 in cycle t+1 only; gnt SHALL be zero or one-hot.
REQ-017 On that same edge, vec[idx[w]] SHALL take val[w] as sampled in cycle t (latency 1).
REQ-018 A requester with gnt high in the current cycle SHALL be ineligible this cycle (no double grant while it drops req).
REQ-019 A requester SHALL hold req, idx and val stable until gnt; deasserting req before gnt withdraws the request with no effect.
REQ-020 chg SHALL pulse in cycle t+1 only if the written bit differs from its prior value; rewriting an equal value SHALL grant but not pulse chg.
REQ-021 If idx[w] >= W, the block SHALL still grant, SHALL leave vec unchanged and SHALL set err, which holds until rst.
REQ-022 Successive grants to the same bit SHALL apply in grant order, so the last grant wins.
REQ-023 The quiet counter SHALL clear on every grant, increment otherwise, and saturate at SETTLE.
REQ-024 stable SHALL be 1 when the quiet counter is at SETTLE.
REQ-025 With a single persistent requester, grants SHALL occur every other cycle (REQ-018); with two or more persistent requesters, one grant SHALL occur every cycle.

Reset
REQ-026 While rst=1, the block SHALL force vec=0, gnt=0, chg=0, err=0, ptr=0 and quiet counter=0, so stable=0.
REQ-027 Arbitration SHALL resume on the first cycle after rst deasserts.
REQ-028 A winner sampled in the cycle rst is high SHALL be discarded, with no grant and no write.

Structure
REQ-029 A shared package update_sched_pkg SHALL hold the default constants for NREQ, W and SETTLE, and the clog2-based IDXW helper.
REQ-030 The round-robin pick SHALL be a sub-module rr_arbiter (inputs req, ptr; outputs one-hot win, valid), purely combinational.
REQ-031 All state registers (ptr, gnt, vec, chg, err, quiet counter) SHALL live in update_sched.

Verification
REQ-032 Reset test: hold rst for 2 cycles, then release with req=0 -> vec=0, gnt=0, err=0; stable rises exactly 3 cycles after release.
REQ-033 Single request: req=0001, idx0=2, val0=1 -> gnt=0001 next cycle; vec=0000000100 and chg=1 in the same cycle; req dropped; stable 3 cycles later.
REQ-034 Round robin: all four req held with distinct idx 0..3 and val=1 -> gnt sequence 0001, 0010, 0100, 1000 on consecutive cycles; vec=0000001111.
REQ-035 Same-bit conflict: req0 (idx 5, val 1) and req1 (idx 5, val 0), both pending with ptr=0 -> vec[5]=1 then 0; chg pulses twice; a repeated write of 0 grants with chg=0.
REQ-036 Out-of-range: req2 with idx=12 -> gnt=0100, vec unchanged, err=1 and held until rst.
REQ-037 Reset mid-operation: assert rst in the cycle a winner is picked -> no gnt and no write afterward; ptr=0 on release.

Source files
------------

// File: rtl/update_sched_pkg.sv
// Shared defaults and sizing helper for the update scheduler and its arbiter.
package update_sched_pkg;

    localparam int NREQ_DEF   = 4;
    localparam int W_DEF      = 10;
    localparam int SETTLE_DEF = 3;

    // Index width for a range of n entries, never narrower than one bit.
    function automatic int idxw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the eligible requester closest to ptr
// (wrapping upward) wins.
module rr_arbiter
    import update_sched_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int PW   = idxw(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] win,
    output logic            valid
);

    always_comb begin
        int best_d;
        int d;
        best_d = NREQ;
        d      = 0;
        win    = '0;
        for (int j = 0; j < NREQ; j++) begin
            d = (j + NREQ - int'(ptr)) % NREQ;
            if (req[j] && d < best_d) begin
                best_d = d;
                win    = '0;
                win[j] = 1'b1;
            end
        end
        valid = |win;
    end

endmodule

// File: rtl/update_sched.sv
// Shared bit-vector update port: round-robin arbitration among NREQ writers,
// one registered write per cycle, change/settle/error status.
module update_sched
    import update_sched_pkg::*;
#(
    parameter int NREQ   = NREQ_DEF,
    parameter int W      = W_DEF,
    parameter int SETTLE = SETTLE_DEF,
    parameter int IDXW   = idxw(W)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*IDXW-1:0] idx,
    input  logic [NREQ-1:0]      val,
    output logic [NREQ-1:0]      gnt,
    output logic [W-1:0]         vec,
    output logic                 chg,
    output logic                 stable,
    output logic                 err
);

    localparam int PW = idxw(NREQ);
    localparam int QW = idxw(SETTLE + 1);
    localparam logic [IDXW:0]   W_LIM    = W[IDXW:0];
    localparam logic [QW-1:0]   SETTLE_Q = QW'(SETTLE);

    logic [PW-1:0]   ptr;
    logic [QW-1:0]   quiet;
    logic [NREQ-1:0] win;
    logic            win_vld;
    logic [IDXW-1:0] wr_idx;
    logic            wr_val;
    logic            in_range;
    logic [PW-1:0]   nxt_ptr;

    // A requester seeing its grant this cycle cannot win again while it drops req.
    rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
        .req   (req & ~gnt),
        .ptr   (ptr),
        .win   (win),
        .valid (win_vld)
    );

    always_comb begin
        wr_idx  = '0;
        wr_val  = 1'b0;
        nxt_ptr = ptr;
        for (int j = 0; j < NREQ; j++) begin
            if (win[j]) begin
                wr_idx  = idx[j*IDXW +: IDXW];
                wr_val  = val[j];
                nxt_ptr = PW'((j + 1) % NREQ);
            end
        end
        in_range = ({1'b0, wr_idx} < W_LIM);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr   <= '0;
            gnt   <= '0;
            vec   <= '0;
            chg   <= 1'b0;
            err   <= 1'b0;
            quiet <= '0;
        end else begin
            gnt <= win;
            chg <= 1'b0;
            if (win_vld) begin
                ptr   <= nxt_ptr;
                quiet <= '0;
                if (in_range) begin
                    vec[wr_idx] <= wr_val;
                    chg         <= (vec[wr_idx] != wr_val);
                end else begin
                    err <= 1'b1;
                end
            end else if (quiet != SETTLE_Q) begin
                quiet <= quiet + 1'b1;
            end
        end
    end

    assign stable = (quiet == SETTLE_Q);

endmodule

// File: tb/tb_update_sched.sv
// Directed plus randomized check of update_sched against a cycle-level
// behavioural model of the arbitration and vector-update rules.
module tb_update_sched;

    localparam int NREQ   = 4;
    localparam int W      = 10;
    localparam int SETTLE = 3;
    localparam int IDXW   = 4;

    logic                       clk = 1'b0;
    logic                       rst;
    logic [NREQ-1:0]            req;
    logic [NREQ-1:0][IDXW-1:0]  idx_a;
    logic [NREQ-1:0]            val;
    logic [NREQ-1:0]            gnt;
    logic [W-1:0]               vec;
    logic                       chg, stable, err;

    int n_checks = 0;
    int n_fail   = 0;

    int              m_ptr;
    logic [W-1:0]    m_vec;
    logic [NREQ-1:0] m_gnt;
    logic            m_chg, m_err;
    int              m_quiet;

    update_sched #(.NREQ(NREQ), .W(W), .SETTLE(SETTLE)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .idx    (idx_a),
        .val    (val),
        .gnt    (gnt),
        .vec    (vec),
        .chg    (chg),
        .stable (stable),
        .err    (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Predict the state after the coming edge from the inputs now applied.
    task automatic model_step();
        int win;
        int ix;
        if (rst) begin
            m_ptr = 0; m_vec = '0; m_gnt = '0; m_chg = 1'b0; m_err = 1'b0; m_quiet = 0;
            return;
        end
        win = -1;
        for (int i = 0; i < NREQ; i++) begin
            int k = (m_ptr + i) % NREQ;
            if (win < 0 && req[k] && !m_gnt[k]) win = k;
        end
        m_chg = 1'b0;
        if (win >= 0) begin
            ix    = int'(idx_a[win]);
            m_ptr = (win + 1) % NREQ;
            if (ix < W) begin
                m_chg     = (m_vec[ix] != val[win]);
                m_vec[ix] = val[win];
            end else begin
                m_err = 1'b1;
            end
            m_quiet = 0;
            m_gnt   = 4'(1 << win);
        end else begin
            m_gnt = '0;
            if (m_quiet < SETTLE) m_quiet++;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("m_gnt", 32'(gnt), 32'(m_gnt));
        check("m_vec", 32'(vec), 32'(m_vec));
        check("m_chg", 32'(chg), 32'(m_chg));
        check("m_err", 32'(err), 32'(m_err));
        check("m_stable", 32'(stable), 32'(m_quiet == SETTLE));
    endtask

    initial begin
        rst = 1'b1; req = '0; idx_a = '0; val = '0;

        // Reset, then quiet count up to stable.
        tick(); tick();
        check("rst_vec", 32'(vec), 0);
        check("rst_gnt", 32'(gnt), 0);
        check("rst_err", 32'(err), 0);
        check("rst_stable", 32'(stable), 0);
        rst = 1'b0;
        tick();
        tick(); check("stable_2", 32'(stable), 0);
        tick(); check("stable_3", 32'(stable), 1);

        // Single request.
        req = 4'b0001; idx_a[0] = 4'd2; val = 4'b0001;
        tick();
        check("single_gnt", 32'(gnt), 32'b0001);
        check("single_vec", 32'(vec), 32'b0000000100);
        check("single_chg", 32'(chg), 1);
        req = '0;
        tick(); check("single_gnt_off", 32'(gnt), 0);
        tick(); check("single_quiet", 32'(stable), 0);
        tick(); tick(); check("single_stable", 32'(stable), 1);

        // Round robin from ptr=0.
        rst = 1'b1; tick(); rst = 1'b0;
        req = 4'hF; val = 4'hF;
        for (int k = 0; k < NREQ; k++) idx_a[k] = 4'(k);
        for (int k = 0; k < NREQ; k++) begin
            tick();
            check("rr_gnt", 32'(gnt), 32'(1 << k));
            req[k] = 1'b0;
        end
        check("rr_vec", 32'(vec), 32'b0000001111);

        // Same-bit conflict, last grant wins; equal rewrite does not pulse chg.
        rst = 1'b1; tick(); rst = 1'b0;
        req = 4'b0011; idx_a[0] = 4'd5; idx_a[1] = 4'd5; val = 4'b0001;
        tick();
        check("conf_gnt0", 32'(gnt), 32'b0001);
        check("conf_vec1", 32'(vec[5]), 1);
        check("conf_chg1", 32'(chg), 1);
        req[0] = 1'b0;
        tick();
        check("conf_gnt1", 32'(gnt), 32'b0010);
        check("conf_vec0", 32'(vec[5]), 0);
        check("conf_chg2", 32'(chg), 1);
        tick();
        check("conf_gap", 32'(gnt), 0);
        tick();
        check("conf_regnt", 32'(gnt), 32'b0010);
        check("conf_nochg", 32'(chg), 0);
        req = '0;
        tick();

        // Out-of-range index: grant, no write, sticky err.
        req = 4'b0100; idx_a[2] = 4'd12; val = 4'b0100;
        tick();
        check("oor_gnt", 32'(gnt), 32'b0100);
        check("oor_vec", 32'(vec), 0);
        check("oor_err", 32'(err), 1);
        req = '0;
        tick(); tick();
        check("oor_sticky", 32'(err), 1);

        // Reset in the cycle a winner is picked; arbitration restarts at ptr=0.
        req = 4'hF; val = 4'hF;
        for (int k = 0; k < NREQ; k++) idx_a[k] = 4'(k + 4);
        rst = 1'b1;
        tick();
        check("mid_gnt", 32'(gnt), 0);
        check("mid_vec", 32'(vec), 0);
        check("mid_err", 32'(err), 0);
        rst = 1'b0;
        tick();
        check("mid_ptr0", 32'(gnt), 32'b0001);
        check("mid_vec4", 32'(vec), 32'b0000010000);
        req = '0;
        tick();

        // Randomized traffic honouring the hold-until-grant protocol.
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 99) < 2);
            for (int k = 0; k < NREQ; k++) begin
                if (!req[k] || gnt[k]) begin
                    req[k]   = 1'($urandom_range(0, 1));
                    idx_a[k] = 4'($urandom_range(0, 13));
                    val[k]   = 1'($urandom_range(0, 1));
                end else if ($urandom_range(0, 9) == 0) begin
                    req[k] = 1'b0;
                end
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
